// File: rtl/ibus_refill_ctrl_if.sv
// Signal bundle around the instruction-cache refill sequencer: lookup-stage
// miss/flush/stall, line-array fill port and the memory read-address/read-data channels.
interface ibus_refill_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 8,
  parameter int ADDR_WIDTH = 32
);
  localparam int IDX_W = $clog2(LINE_WORDS);

  logic                  miss_req;
  logic [ADDR_WIDTH-1:0] miss_addr;
  logic                  flush;
  logic                  stall;
  logic                  busy;
  logic                  fill_we;
  logic [IDX_W-1:0]      fill_idx;
  logic [DATA_WIDTH-1:0] fill_data;
  logic                  fill_tag_we;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic                  mem_ar_valid;
  logic                  mem_ar_ready;
  logic [ADDR_WIDTH-1:0] mem_ar_addr;
  logic [7:0]            mem_ar_len;
  logic                  mem_r_valid;
  logic                  mem_r_ready;
  logic [DATA_WIDTH-1:0] mem_r_data;
  logic                  mem_r_last;
  logic                  proto_err;

  modport master (
    input  miss_req, miss_addr, flush, mem_ar_ready, mem_r_valid, mem_r_data, mem_r_last,
    output stall, busy, fill_we, fill_idx, fill_data, fill_tag_we, fill_addr,
           mem_ar_valid, mem_ar_addr, mem_ar_len, mem_r_ready, proto_err
  );

  modport slave (
    output miss_req, miss_addr, flush, mem_ar_ready, mem_r_valid, mem_r_data, mem_r_last,
    input  stall, busy, fill_we, fill_idx, fill_data, fill_tag_we, fill_addr,
           mem_ar_valid, mem_ar_addr, mem_ar_len, mem_r_ready, proto_err
  );
endinterface

// File: rtl/ibus_refill_ctrl.sv
// Instruction-cache refill sequencer: on a miss, issues one line-aligned burst,
// streams the returned words into the line array and commits the tag.
module ibus_refill_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  ibus_refill_ctrl_if.master bus
);
  localparam int IDX_W    = $clog2(LINE_WORDS);
  localparam int OFF_BITS = $clog2(LINE_WORDS * DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((64'd1 << OFF_BITS) - 64'd1);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(LINE_WORDS - 1);
  localparam logic [7:0]            AR_LEN    = 8'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_DATA   = 3'd2,
    S_COMMIT = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  state_t                state_r, state_nx_s;
  logic [IDX_W-1:0]      count_r, count_nx_s;
  logic [ADDR_WIDTH-1:0] fill_addr_r, addr_nx_s;
  logic                  abort_r, abort_nx_s;
  logic                  proto_err_r, perr_nx_s;
  logic                  ar_valid_r;
  logic                  tag_we_r;
  logic                  busy_r;
  logic                  stall_s;
  logic                  fill_we_s;
  logic                  r_ready_s;
  logic                  miss_ok_s;

  assign miss_ok_s = bus.miss_req & ~bus.flush;

  // State and datapath registers; ar_valid/tag_we/busy are decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      count_r     <= {IDX_W{1'b0}};
      fill_addr_r <= {ADDR_WIDTH{1'b0}};
      abort_r     <= 1'b0;
      proto_err_r <= 1'b0;
      ar_valid_r  <= 1'b0;
      tag_we_r    <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      count_r     <= count_nx_s;
      fill_addr_r <= addr_nx_s;
      abort_r     <= abort_nx_s;
      proto_err_r <= perr_nx_s;
      ar_valid_r  <= (state_nx_s == S_ADDR);
      tag_we_r    <= (state_nx_s == S_COMMIT);
      busy_r      <= (state_nx_s != S_IDLE);
    end
  end

  // Next-state, fill strobes, read-data ready and pipeline stall.
  always_comb begin
    state_nx_s = state_r;
    count_nx_s = count_r;
    addr_nx_s  = fill_addr_r;
    abort_nx_s = abort_r;
    perr_nx_s  = proto_err_r;
    stall_s    = 1'b0;
    fill_we_s  = 1'b0;
    r_ready_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (miss_ok_s) begin
          stall_s    = 1'b1;
          addr_nx_s  = bus.miss_addr & LINE_MASK;
          count_nx_s = {IDX_W{1'b0}};
          abort_nx_s = 1'b0;
          state_nx_s = S_ADDR;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_ADDR: begin
        stall_s = 1'b1;
        if (ar_valid_r && bus.mem_ar_ready) begin
          abort_nx_s = 1'b0;
          if (abort_r || bus.flush) begin
            state_nx_s = S_DRAIN;
          end else begin
            state_nx_s = S_DATA;
          end
        end else begin
          // A flush here cannot cancel the pending address, so remember it.
          abort_nx_s = abort_r | bus.flush;
        end
      end
      S_DATA: begin
        stall_s   = 1'b1;
        r_ready_s = 1'b1;
        if (bus.flush) begin
          // A flush arriving with the final beat has nothing left to drain.
          if (bus.mem_r_valid && bus.mem_r_last) begin
            state_nx_s = S_IDLE;
          end else begin
            state_nx_s = S_DRAIN;
          end
        end else if (bus.mem_r_valid) begin
          fill_we_s  = 1'b1;
          count_nx_s = count_r + IDX_W'(1);
          if (bus.mem_r_last) begin
            if (count_r == LAST_IDX) begin
              state_nx_s = S_COMMIT;
            end else begin
              perr_nx_s  = 1'b1;
              state_nx_s = S_IDLE;
            end
          end else if (count_r == LAST_IDX) begin
            perr_nx_s  = 1'b1;
            state_nx_s = S_IDLE;
          end else begin
            state_nx_s = S_DATA;
          end
        end else begin
          state_nx_s = S_DATA;
        end
      end
      S_COMMIT: begin
        stall_s    = 1'b1;
        state_nx_s = S_IDLE;
      end
      S_DRAIN: begin
        r_ready_s = 1'b1;
        stall_s   = miss_ok_s;
        if (bus.mem_r_valid && bus.mem_r_last) begin
          state_nx_s = S_IDLE;
        end else begin
          state_nx_s = S_DRAIN;
        end
      end
      default: begin
        abort_nx_s = 1'b0;
        state_nx_s = S_IDLE;
      end
    endcase
  end

  assign bus.stall        = stall_s;
  assign bus.busy         = busy_r;
  assign bus.fill_we      = fill_we_s;
  assign bus.fill_idx     = count_r;
  assign bus.fill_data    = bus.mem_r_data;
  assign bus.fill_tag_we  = tag_we_r;
  assign bus.fill_addr    = fill_addr_r;
  assign bus.mem_ar_valid = ar_valid_r;
  assign bus.mem_ar_addr  = fill_addr_r;
  assign bus.mem_ar_len   = AR_LEN;
  assign bus.mem_r_ready  = r_ready_s;
  assign bus.proto_err    = proto_err_r;
endmodule

// File: tb/tb_ibus_refill_ctrl.sv
// Randomised scoreboard bench for ibus_refill_ctrl: the stimulus side queues the
// expected address, word writes and tag commits; a negedge monitor pops and compares.
module tb_ibus_refill_ctrl;
  localparam int DATA_WIDTH = 32;
  localparam int LINE_WORDS = 8;
  localparam int ADDR_WIDTH = 32;
  localparam int IDX_W      = $clog2(LINE_WORDS);
  localparam logic [31:0] LINE_BYTES = 32'(LINE_WORDS * DATA_WIDTH / 8);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [31:0]      data;
  } fill_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  bit   exp_perr = 1'b0;

  logic [31:0] ar_q[$];
  logic [31:0] tag_q[$];
  fill_t       fill_q[$];
  logic [31:0] mon_a;
  fill_t       mon_f;

  ibus_refill_ctrl_if #(.DATA_WIDTH(DATA_WIDTH), .LINE_WORDS(LINE_WORDS), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  ibus_refill_ctrl #(.DATA_WIDTH(DATA_WIDTH), .LINE_WORDS(LINE_WORDS), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    $display("FAIL %s: DUT strobe with nothing expected (cycle %0d)", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_ar_valid && bus.mem_ar_ready) begin
        if (ar_q.size() == 0) unexpected("ar_handshake");
        else begin
          mon_a = ar_q.pop_front();
          chk("ar_addr", 64'(bus.mem_ar_addr), 64'(mon_a));
          chk("ar_len", 64'(bus.mem_ar_len), 64'(LINE_WORDS - 1));
        end
      end
      if (bus.fill_we) begin
        if (fill_q.size() == 0) unexpected("fill_we");
        else begin
          mon_f = fill_q.pop_front();
          chk("fill_idx", 64'(bus.fill_idx), 64'(mon_f.idx));
          chk("fill_data", 64'(bus.fill_data), 64'(mon_f.data));
        end
      end
      if (bus.fill_tag_we) begin
        if (tag_q.size() == 0) unexpected("fill_tag_we");
        else begin
          mon_a = tag_q.pop_front();
          chk("tag_addr", 64'(bus.fill_addr), 64'(mon_a));
        end
      end
    end
  end

  // One refill as seen from the requester and the memory. flush_beat<0: no flush in DATA;
  // last_beat: index of the beat carrying r_last; chain_miss raises a new miss mid-drain.
  task automatic refill(input logic [31:0] addr, input int ar_delay, input bit gap,
                        input int flush_beat, input int last_beat, input bit flush_addr,
                        input bit rand_data, input bit chain_miss, input logic [31:0] chain_addr);
    logic [31:0] line;
    logic [31:0] d;
    bit          filling;
    bit          commit;
    bit          exp_stall;
    int          t_miss;
    line    = (addr / LINE_BYTES) * LINE_BYTES;
    filling = !flush_addr;
    commit  = !flush_addr && flush_beat < 0 && last_beat == LINE_WORDS - 1;
    if (!flush_addr && flush_beat < 0 && last_beat != LINE_WORDS - 1) exp_perr = 1'b1;

    chk("idle_busy", 64'(bus.busy), 64'(0));
    bus.miss_req  = 1'b1;
    bus.miss_addr = addr;
    t_miss = cyc;
    #1;
    chk("idle_miss_stall", 64'(bus.stall), 64'(1));
    ar_q.push_back(line);
    tick();
    #1;
    chk("addr_ar_valid", 64'(bus.mem_ar_valid), 64'(1));
    chk("addr_stall", 64'(bus.stall), 64'(1));
    chk("addr_busy", 64'(bus.busy), 64'(1));

    if (flush_addr) begin
      bus.flush        = 1'b1;
      bus.mem_ar_ready = 1'b0;
      tick();
      bus.flush    = 1'b0;
      bus.miss_req = 1'b0;
    end
    for (int k = 0; k < ar_delay; k++) begin
      #1;
      chk("ar_hold_valid", 64'(bus.mem_ar_valid), 64'(1));
      chk("ar_hold_addr", 64'(bus.mem_ar_addr), 64'(line));
      tick();
    end
    bus.mem_ar_ready = 1'b1;
    tick();
    bus.mem_ar_ready = 1'b0;

    for (int i = 0; i <= last_beat; i++) begin
      if (gap) begin
        bus.mem_r_valid = 1'b0;
        bus.mem_r_last  = 1'b0;
        tick();
      end
      d = rand_data ? $urandom : 32'hA0 + 32'(i);
      bus.mem_r_valid = 1'b1;
      bus.mem_r_data  = d;
      bus.mem_r_last  = (i == last_beat);
      exp_stall       = chain_miss && i >= 4;
      if (i == flush_beat) begin
        bus.flush    = 1'b1;
        bus.miss_req = 1'b0;
        filling      = 1'b0;
      end else if (filling) begin
        fill_q.push_back('{idx: IDX_W'(i), data: d});
        #1;
        chk("data_stall", 64'(bus.stall), 64'(1));
        chk("data_r_ready", 64'(bus.mem_r_ready), 64'(1));
      end else begin
        if (exp_stall) begin
          bus.miss_req  = 1'b1;
          bus.miss_addr = chain_addr;
        end
        #1;
        chk("drain_busy", 64'(bus.busy), 64'(1));
        chk("drain_stall", 64'(bus.stall), 64'(exp_stall));
        chk("drain_no_ar", 64'(bus.mem_ar_valid), 64'(0));
      end
      if (commit && i == last_beat) tag_q.push_back(line);
      if (!commit && !chain_miss && i == last_beat) bus.miss_req = 1'b0;
      tick();
      bus.flush = 1'b0;
    end
    bus.mem_r_valid = 1'b0;
    bus.mem_r_last  = 1'b0;

    if (commit) begin
      bus.miss_req = 1'b0;
      #1;
      chk("commit_busy", 64'(bus.busy), 64'(1));
      if (ar_delay == 0 && !gap) chk("miss_to_commit", 64'(cyc - t_miss), 64'(2 + LINE_WORDS));
      tick();
    end
    #1;
    chk("proto_err", 64'(bus.proto_err), 64'(exp_perr));
  endtask

  initial begin
    int          sel;
    int          fb;
    bit          fa;
    logic [31:0] a2;
    rst_n = 1'b0;
    bus.miss_req = 1'b0;
    bus.miss_addr = 32'h0;
    bus.flush = 1'b0;
    bus.mem_ar_ready = 1'b0;
    bus.mem_r_valid = 1'b0;
    bus.mem_r_data = 32'h0;
    bus.mem_r_last = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_stall", 64'(bus.stall), 64'(0));
    chk("rst_ar_valid", 64'(bus.mem_ar_valid), 64'(0));
    chk("rst_r_ready", 64'(bus.mem_r_ready), 64'(0));
    chk("rst_fill_we", 64'(bus.fill_we), 64'(0));
    chk("rst_tag_we", 64'(bus.fill_tag_we), 64'(0));
    chk("rst_fill_addr", 64'(bus.fill_addr), 64'(0));
    chk("rst_proto_err", 64'(bus.proto_err), 64'(0));
    rst_n = 1'b1;
    tick();

    refill(32'h1FC0_0014, 0, 1'b0, -1, 7, 1'b0, 1'b0, 1'b0, 32'h0);   // basic line
    refill($urandom, 3, 1'b0, -1, 7, 1'b0, 1'b1, 1'b0, 32'h0);        // ar backpressure
    refill($urandom, 0, 1'b0, 3, 7, 1'b0, 1'b1, 1'b0, 32'h0);         // flush in DATA
    a2 = $urandom;
    refill($urandom, 2, 1'b0, -1, 7, 1'b1, 1'b1, 1'b1, a2);           // flush in ADDR, miss in DRAIN
    refill(a2, 0, 1'b0, -1, 7, 1'b0, 1'b1, 1'b0, 32'h0);
    refill($urandom, 0, 1'b1, -1, 7, 1'b0, 1'b1, 1'b0, 32'h0);        // r_valid gaps

    for (int n = 0; n < 16; n++) begin
      sel = $urandom_range(0, 9);
      fb  = (sel < 2) ? int'($urandom_range(0, 7)) : -1;
      fa  = (sel == 2);
      refill($urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), fb, 7, fa,
             1'b1, 1'b0, 32'h0);
    end

    refill($urandom, 0, 1'b0, -1, 5, 1'b0, 1'b1, 1'b0, 32'h0);        // early r_last
    refill($urandom, 1, 1'b1, -1, 7, 1'b0, 1'b1, 1'b0, 32'h0);        // proto_err stays set

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_perr = 1'b0;
    #1;
    chk("rst2_proto_err", 64'(bus.proto_err), 64'(0));
    chk("rst2_busy", 64'(bus.busy), 64'(0));
    refill($urandom, 0, 1'b0, -1, 7, 1'b0, 1'b1, 1'b0, 32'h0);

    repeat (3) tick();
    chk("ar_q_drained", 64'(ar_q.size()), 64'(0));
    chk("fill_q_drained", 64'(fill_q.size()), 64'(0));
    chk("tag_q_drained", 64'(tag_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
